error_sequencer: RTL and testbench
==================================

# error_sequencer

Scheduled error-injection controller for the BTE. It drives the ERROR block's start strobe, target select and type select from a small programmable table in place of the slide switches and push button. Entries are replayed in order, and each is held for a programmable number of 5 ms ticks from the TIMERS block. Issue is held off while the ERROR report FIFO is full, so no injection report is lost before FIFO_ARBITER drains it.

## Interface

- DEPTH, 8: number of table entries (power of two, 2..16).
- IDX_W, 3: index width, log2(DEPTH).
- HOLD_W, 8: hold-count width, in PULSE_5MS ticks.
- CLK  in  1  system clock (clk_int). Single clock domain.
- RESET  in  1  synchronous, active-high reset.
- PULSE_5MS  in  1  one-cycle tick from TIMERS.
- LOAD_WR  in  1  table write strobe.
- LOAD_ADDR  in  IDX_W  table write address.
- LOAD_DATA  in  6+HOLD_W  entry {target[1:0], type[3:0], hold[HOLD_W-1:0]}.
- LAST_INDEX  in  IDX_W  index of the final entry in the sequence.
- LOOP  in  1  when 1, restart at entry 0 after LAST_INDEX.
- RUN  in  1  start request; level, acted on only in IDLE.
- ABORT  in  1  stop request; highest priority.
- ERROR_FIFO_FULL  in  1  backpressure from ERROR.
- ERR_START  out  1  one-cycle start strobe to ERROR.
- ERR_TARGET  out  2  target select to ERROR.
- ERR_TYPE  out  4  type select to ERROR.
- BUSY  out  1  high whenever state ≠ IDLE.
- DONE  out  1  one-cycle pulse on normal completion.
- CUR_INDEX  out  IDX_W  index of the entry in progress.

## Operation

- Table: DEPTH registers. RESET clears all of them to 0.
  - LOAD_WR writes LOAD_DATA to LOAD_ADDR only when BUSY=0.
  - LOAD_WR while BUSY=1 is ignored and leaves the table unchanged.
- States: IDLE, ISSUE, HOLD.
- IDLE:
  - CUR_INDEX is held at 0.
  - RUN=1 → ISSUE, hold counter cleared.
- ISSUE:
  - If ERROR_FIFO_FULL=1, remain in ISSUE with no strobe.
  - Otherwise: ERR_START=1 for that cycle, ERR_TARGET/ERR_TYPE loaded from table[CUR_INDEX], hold counter cleared, → HOLD.
- HOLD:
  - PULSE_5MS increments the hold counter.
  - When the counter equals the entry's hold field, go to the advance step below. The compare is made before the increment, so hold=0 exits on the first HOLD cycle.
- Advance:
  - CUR_INDEX≠LAST_INDEX → CUR_INDEX+1, go to ISSUE.
  - CUR_INDEX=LAST_INDEX with LOOP=1 → CUR_INDEX=0, go to ISSUE.
  - CUR_INDEX=LAST_INDEX with LOOP=0 → DONE=1 for one cycle, go to IDLE.
- ABORT=1 in any state → IDLE on the next edge.
  - ERR_START is forced to 0 in that cycle and DONE is not asserted.
  - ERR_TARGET and ERR_TYPE are cleared to 0.
- LAST_INDEX, LOOP and the table entry are sampled at their point of use; they are not latched at RUN.
- Arithmetic:
  - The hold counter is HOLD_W bits and saturates; it never wraps.
  - CUR_INDEX wraps only through LOOP. LAST_INDEX=DEPTH-1 is legal.
- RESET → IDLE. Reset values:
  - ERR_START=0, ERR_TARGET=0, ERR_TYPE=0.
  - BUSY=0, DONE=0, CUR_INDEX=0, hold counter=0.

## Timing

- All outputs are registered.
- Start latency: RUN sampled at edge t.
  - BUSY=1 and state=ISSUE from t+1.
  - ERR_START asserted in the cycle after ISSUE is entered, i.e. registered at t+2, given FIFO not full.
- ERR_TARGET/ERR_TYPE become valid in the same cycle as ERR_START and stay stable until the next strobe or abort.
- Strobe spacing with hold=0: 2 cycles between consecutive ERR_START pulses.
- Strobe spacing with hold=h>0: the next strobe follows the h-th PULSE_5MS counted in HOLD, plus 2 cycles. A PULSE_5MS coinciding with the ISSUE cycle is not counted.
- ERROR_FIFO_FULL is sampled every ISSUE cycle. The strobe fires in the first cycle after FULL is sampled 0.
- Simultaneous events:
  - ABORT beats RUN, advance and RESET-free transitions.
  - RUN while BUSY is ignored.
  - RUN held high in IDLE after DONE restarts the sequence (re-arm).
- DONE and BUSY fall together. DONE is high in the first IDLE cycle.

## Test plan

- Reset then idle:
  - Stimulus: assert RESET for 2 cycles.
  - Response: all outputs 0; a table read by run shows ERR_TYPE=0.
- Three-entry run:
  - Stimulus: load {1,4'h3,2}, {2,4'h5,0}, {0,4'hA,1}; LAST_INDEX=2; LOOP=0; pulse RUN.
  - Response: strobes with (1,3), (2,5), (0,A); 2 ticks after the first strobe, 0 ticks after the second; DONE once, 1 tick after the third; BUSY 0 afterwards.
- Backpressure:
  - Stimulus: ERROR_FIFO_FULL=1 for 10 cycles during ISSUE.
  - Response: no ERR_START during those cycles; exactly one strobe in the cycle after FULL drops; CUR_INDEX unchanged while held.
- Loop:
  - Stimulus: LAST_INDEX=1, LOOP=1, holds 0.
  - Response: CUR_INDEX sequence 0,1,0,1… with strobes every 2 cycles; DONE never asserted.
- Abort mid-hold:
  - Stimulus: ABORT during HOLD of entry 1.
  - Response: IDLE next cycle; BUSY=0, DONE=0, CUR_INDEX=0, ERR_TARGET/ERR_TYPE=0; a following RUN restarts at entry 0.
- Load while busy:
  - Stimulus: LOAD_WR to entry 0 during a run.
  - Response: the table is unchanged, and the next run replays the original entry 0 values.

Source files
------------

// File: rtl/error_sequencer.sv
`timescale 1ns/1ps
// error_sequencer
// Replays a small programmable table of error injections into the ERROR block.
// Each entry selects a target and an error type and is held for a number of
// 5 ms ticks before the next entry is issued. Issue stalls while the ERROR
// report FIFO is full, so no injection report is dropped.
//
// Ports:
//   clk_i              system clock
//   reset_i            synchronous active-high reset
//   pulse_5ms_i        one-cycle tick from TIMERS
//   load_wr_i          table write strobe (honoured only while idle)
//   load_addr_i        table write address
//   load_data_i        entry {target[1:0], type[3:0], hold[HOLD_W-1:0]}
//   last_index_i       index of the final entry in the sequence
//   loop_i             restart at entry 0 after last_index_i
//   run_i              start request (level, acted on only when idle)
//   abort_i            stop request, highest priority
//   error_fifo_full_i  backpressure from ERROR
//   err_start_o        one-cycle start strobe to ERROR
//   err_target_o       target select to ERROR
//   err_type_o         type select to ERROR
//   busy_o             high whenever the sequencer is not idle
//   done_o             one-cycle pulse on normal completion
//   cur_index_o        index of the entry in progress
module error_sequencer #(
    parameter int DEPTH  = 8,
    parameter int IDX_W  = 3,
    parameter int HOLD_W = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              pulse_5ms_i,
    input  logic              load_wr_i,
    input  logic [IDX_W-1:0]  load_addr_i,
    input  logic [HOLD_W+5:0] load_data_i,
    input  logic [IDX_W-1:0]  last_index_i,
    input  logic              loop_i,
    input  logic              run_i,
    input  logic              abort_i,
    input  logic              error_fifo_full_i,
    output logic              err_start_o,
    output logic [1:0]        err_target_o,
    output logic [3:0]        err_type_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [IDX_W-1:0]  cur_index_o
);

    localparam int ENTRY_W = HOLD_W + 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    cur_index_q, cur_index_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                err_start_q, err_start_d;
    logic [1:0]          err_target_q, err_target_d;
    logic [3:0]          err_type_q, err_type_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;

    logic [ENTRY_W-1:0]  tbl_q [DEPTH];

    logic [ENTRY_W-1:0]  cur_entry;
    logic [1:0]          cur_target;
    logic [3:0]          cur_type;
    logic [HOLD_W-1:0]   cur_hold;

    // Table storage. Writes are locked out while a sequence is running so the
    // entry being replayed can never change underneath it.
    // NOTE: the table is small and reset-to-zero is part of its contract, so
    // it is built from resettable flops rather than an inferred RAM.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (load_wr_i && !busy_q) begin
            tbl_q[load_addr_i] <= load_data_i;
        end
    end

    assign cur_entry  = tbl_q[cur_index_q];
    assign cur_target = cur_entry[ENTRY_W-1 -: 2];
    assign cur_type   = cur_entry[HOLD_W+3 -: 4];
    assign cur_hold   = cur_entry[HOLD_W-1:0];

    // NOTE: every _d signal takes its default before the case statement so no
    // path through this block leaves a signal unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        cur_index_d  = cur_index_q;
        hold_cnt_d   = hold_cnt_q;
        err_start_d  = 1'b0;
        err_target_d = err_target_q;
        err_type_d   = err_type_q;
        done_d       = 1'b0;

        if (abort_i) begin
            state_d      = ST_IDLE;
            cur_index_d  = '0;
            hold_cnt_d   = '0;
            err_target_d = '0;
            err_type_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    cur_index_d = '0;
                    if (run_i) begin
                        state_d    = ST_ISSUE;
                        hold_cnt_d = '0;
                    end
                end

                ST_ISSUE: begin
                    // Clearing the counter here also discards any tick that
                    // lands in the issue cycle.
                    if (!error_fifo_full_i) begin
                        err_start_d  = 1'b1;
                        err_target_d = cur_target;
                        err_type_d   = cur_type;
                        hold_cnt_d   = '0;
                        state_d      = ST_HOLD;
                    end
                end

                ST_HOLD: begin
                    // Compare before increment: hold=0 leaves on the first
                    // HOLD cycle.
                    if (hold_cnt_q == cur_hold) begin
                        if (cur_index_q != last_index_i) begin
                            cur_index_d = cur_index_q + IDX_W'(1);
                            state_d     = ST_ISSUE;
                        end else if (loop_i) begin
                            cur_index_d = '0;
                            state_d     = ST_ISSUE;
                        end else begin
                            cur_index_d = '0;
                            done_d      = 1'b1;
                            state_d     = ST_IDLE;
                        end
                    end else if (pulse_5ms_i && (hold_cnt_q != '1)) begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end

                default: begin
                    state_d     = ST_IDLE;
                    cur_index_d = '0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            cur_index_q  <= '0;
            hold_cnt_q   <= '0;
            err_start_q  <= 1'b0;
            err_target_q <= '0;
            err_type_q   <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_index_q  <= cur_index_d;
            hold_cnt_q   <= hold_cnt_d;
            err_start_q  <= err_start_d;
            err_target_q <= err_target_d;
            err_type_q   <= err_type_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign err_start_o  = err_start_q;
    assign err_target_o = err_target_q;
    assign err_type_o   = err_type_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign cur_index_o  = cur_index_q;

endmodule

// File: tb/tb_error_sequencer.sv
`timescale 1ns/1ps
// tb_error_sequencer
// Directed bench for error_sequencer: reset clearing of the table, a
// three-entry run with hold ticks, FIFO backpressure, looping, abort, loads
// while busy and re-arm. Expected values are hand-derived cycle by cycle.
module tb_error_sequencer;

    localparam int DEPTH  = 8;
    localparam int IDX_W  = 3;
    localparam int HOLD_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              pulse_5ms = 1'b0;
    logic              load_wr = 1'b0;
    logic [IDX_W-1:0]  load_addr = '0;
    logic [HOLD_W+5:0] load_data = '0;
    logic [IDX_W-1:0]  last_index = '0;
    logic              loop_en = 1'b0;
    logic              run = 1'b0;
    logic              abort = 1'b0;
    logic              fifo_full = 1'b0;
    logic              err_start;
    logic [1:0]        err_target;
    logic [3:0]        err_type;
    logic              busy;
    logic              done;
    logic [IDX_W-1:0]  cur_index;

    int n_checks = 0;
    int n_fail   = 0;

    error_sequencer #(.DEPTH(DEPTH), .IDX_W(IDX_W), .HOLD_W(HOLD_W)) dut (
        .clk_i             (clk),
        .reset_i           (reset),
        .pulse_5ms_i       (pulse_5ms),
        .load_wr_i         (load_wr),
        .load_addr_i       (load_addr),
        .load_data_i       (load_data),
        .last_index_i      (last_index),
        .loop_i            (loop_en),
        .run_i             (run),
        .abort_i           (abort),
        .error_fifo_full_i (fifo_full),
        .err_start_o       (err_start),
        .err_target_o      (err_target),
        .err_type_o        (err_type),
        .busy_o            (busy),
        .done_o            (done),
        .cur_index_o       (cur_index)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to 1 ns after the next rising edge: outputs are settled and
    // newly driven inputs are sampled at the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_pulse();
        pulse_5ms = 1'b1;
        tick();
        pulse_5ms = 1'b0;
    endtask

    task automatic load_entry(input int addr, input int tgt, input int typ, input int hold);
        load_wr   = 1'b1;
        load_addr = IDX_W'(addr);
        load_data = {2'(tgt), 4'(typ), HOLD_W'(hold)};
        tick();
        load_wr   = 1'b0;
    endtask

    task automatic expect_strobe(input string tag, input int tgt, input int typ, input int idx);
        check({tag, ".start"},  32'(err_start),  1);
        check({tag, ".target"}, 32'(err_target), 32'(tgt));
        check({tag, ".type"},   32'(err_type),   32'(typ));
        check({tag, ".index"},  32'(cur_index),  32'(idx));
    endtask

    task automatic expect_idle(input string tag, input int done_exp);
        check({tag, ".busy"},  32'(busy),      0);
        check({tag, ".done"},  32'(done),      32'(done_exp));
        check({tag, ".start"}, 32'(err_start), 0);
        check({tag, ".index"}, 32'(cur_index), 0);
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        // ---------------- reset, and reset clears the table ----------------
        tick();
        tick();
        reset = 1'b0;
        expect_idle("rst", 0);
        check("rst.target", 32'(err_target), 0);
        check("rst.type",   32'(err_type),   0);

        load_entry(0, 3, 4'hF, 0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        last_index = 3'd0;
        loop_en    = 1'b0;
        run = 1'b1;
        tick();
        run = 1'b0;
        check("rst_run.busy", 32'(busy), 1);
        check("rst_run.start_early", 32'(err_start), 0);
        tick();
        expect_strobe("rst_run.strobe", 0, 0, 0);
        tick();
        expect_idle("rst_run.end", 1);
        tick();
        check("rst_run.done_clr", 32'(done), 0);

        // ---------------- three-entry run ----------------
        load_entry(0, 1, 4'h3, 2);
        load_entry(1, 2, 4'h5, 0);
        load_entry(2, 0, 4'hA, 1);
        last_index = 3'd2;
        loop_en    = 1'b0;
        run = 1'b1;
        tick();
        run = 1'b0;
        check("three.busy", 32'(busy), 1);
        check("three.issue_nostart", 32'(err_start), 0);
        tick();
        expect_strobe("three.s0", 1, 4'h3, 0);
        tick_pulse();
        check("three.h1.start", 32'(err_start), 0);
        tick();
        tick();
        check("three.h1b.index", 32'(cur_index), 0);
        tick_pulse();
        check("three.h2.start", 32'(err_start), 0);
        check("three.h2.index", 32'(cur_index), 0);
        tick();
        check("three.adv1.index", 32'(cur_index), 1);
        check("three.adv1.start", 32'(err_start), 0);
        tick();
        expect_strobe("three.s1", 2, 4'h5, 1);
        tick();
        check("three.adv2.index", 32'(cur_index), 2);
        check("three.adv2.start", 32'(err_start), 0);
        tick();
        expect_strobe("three.s2", 0, 4'hA, 2);
        tick();
        check("three.wait.busy", 32'(busy), 1);
        tick_pulse();
        check("three.last.busy", 32'(busy), 1);
        check("three.last.done", 32'(done), 0);
        tick();
        expect_idle("three.end", 1);
        check("three.end.type_kept", 32'(err_type), 32'h A);
        tick();
        check("three.done_once", 32'(done), 0);

        // ---------------- backpressure ----------------
        load_entry(0, 2, 4'h7, 1);
        last_index = 3'd0;
        fifo_full  = 1'b1;
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            // ticks during the stalled issue cycles must not count toward hold
            pulse_5ms = (i % 3 == 0);
            tick();
            check("bp.nostart", 32'(err_start), 0);
            check("bp.index",   32'(cur_index), 0);
            check("bp.busy",    32'(busy),      1);
        end
        pulse_5ms = 1'b0;
        fifo_full = 1'b0;
        tick();
        expect_strobe("bp.strobe", 2, 4'h7, 0);
        tick();
        check("bp.after.start", 32'(err_start), 0);
        tick();
        check("bp.hold.busy", 32'(busy), 1);
        tick_pulse();
        check("bp.tick.busy", 32'(busy), 1);
        tick();
        expect_idle("bp.end", 1);

        // ---------------- loop ----------------
        load_entry(0, 1, 4'h1, 0);
        load_entry(1, 2, 4'h2, 0);
        last_index = 3'd1;
        loop_en    = 1'b1;
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            expect_strobe("loop.strobe", (k % 2) + 1, (k % 2) + 1, k % 2);
            check("loop.done", 32'(done), 0);
            tick();
            check("loop.gap",  32'(err_start), 0);
            check("loop.next", 32'(cur_index), 32'((k + 1) % 2));
        end
        do_abort();
        expect_idle("loop.abort", 0);
        loop_en = 1'b0;

        // ---------------- abort mid-hold ----------------
        load_entry(0, 1, 4'h4, 0);
        load_entry(1, 3, 4'h9, 5);
        last_index = 3'd1;
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        expect_strobe("ab.s0", 1, 4'h4, 0);
        tick();
        tick();
        expect_strobe("ab.s1", 3, 4'h9, 1);
        tick();
        check("ab.hold.index", 32'(cur_index), 1);
        abort = 1'b1;
        run   = 1'b1;
        tick();
        expect_idle("ab.idle", 0);
        check("ab.target", 32'(err_target), 0);
        check("ab.type",   32'(err_type),   0);
        tick();
        check("ab.beats_run", 32'(busy), 0);
        abort = 1'b0;
        tick();
        check("ab.restart.busy",  32'(busy),      1);
        check("ab.restart.index", 32'(cur_index), 0);
        run = 1'b0;
        tick();
        expect_strobe("ab.restart.s0", 1, 4'h4, 0);
        do_abort();

        // ---------------- load while busy ----------------
        run = 1'b1;
        tick();
        run = 1'b0;
        load_entry(0, 3, 4'hF, 0);
        expect_strobe("lwb.s0", 1, 4'h4, 0);
        do_abort();
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        expect_strobe("lwb.replay", 1, 4'h4, 0);
        do_abort();

        // ---------------- re-arm with RUN held ----------------
        last_index = 3'd0;
        run = 1'b1;
        tick();
        tick();
        expect_strobe("rearm.s0", 1, 4'h4, 0);
        tick();
        expect_idle("rearm.done", 1);
        tick();
        check("rearm.busy", 32'(busy), 1);
        run = 1'b0;
        do_abort();
        expect_idle("rearm.abort", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
